// File: rtl/vector_regfile_seq.sv
// Sequenced vector register file: streams three operand groups out beat by beat and
// takes result beats back. Optional `VRF_MASK_EN adds req_mask_en (v0-driven write mask).
module vector_regfile_seq #(
  parameter int VLEN  = 32,
  parameter int LANES = 4,
  parameter int VLW   = $clog2(32*VLEN/8)+1
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_vs1,
  input  logic [4:0]            req_vs2,
  input  logic [4:0]            req_vd,
  input  logic [1:0]            req_vsew,
  input  logic [VLW-1:0]        req_vl,
`ifdef VRF_MASK_EN
  input  logic                  req_mask_en,
`endif
  output logic                  req_err,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic [32*LANES-1:0]   rd_vs1_data,
  output logic [32*LANES-1:0]   rd_vs2_data,
  output logic [32*LANES-1:0]   rd_vs3_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [32*LANES-1:0]   wr_data,
  output logic                  busy
);
  localparam int VB    = VLEN/8;
  localparam int VBL   = $clog2(VB);
  localparam int NB    = 32*VB;
  localparam int ABITS = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t         r_state;
  logic [4:0]     r_vs1, r_vs2, r_vd;
  logic [1:0]     r_vsew;
  logic [VLW-1:0] r_vl, r_rd_cnt, r_wr_cnt;
  logic           r_err;
  logic [7:0]     r_mem [NB];
`ifdef VRF_MASK_EN
  logic           r_mask_en;
`endif

  logic [31:0]      w_beats;
  logic             w_wr_fire;
  logic [LANES-1:0] w_wr_en;
  logic [31:0]      w_wr_off [LANES];

  // The register file is one flat byte space, so group wrap modulo 32 falls out of truncation.
  function automatic logic [ABITS-1:0] f_addr(input logic [4:0] base, input logic [31:0] off,
                                              input logic [31:0] b);
    logic [31:0] a;
    a = (32'(base) << VBL) + off + b;
    return a[ABITS-1:0];
  endfunction

  assign w_beats   = (32'(r_vl) + 32'(LANES-1)) / 32'(LANES);
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rd_valid  = (r_state == S_RUN);
  assign rd_last   = rd_valid && (32'(r_rd_cnt) + 32'd1 == w_beats);
  assign wr_ready  = (r_state == S_RUN || r_state == S_DRAIN) && (r_wr_cnt < r_rd_cnt);
  assign w_wr_fire = wr_valid && wr_ready;
  assign req_err   = r_err;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [31:0] w_erd, w_ewr, w_ord;
    logic        w_ard, w_mok;
    logic [31:0] w_l1, w_l2, w_l3;

    assign w_erd       = 32'(r_rd_cnt) * 32'(LANES) + 32'(k);
    assign w_ewr       = 32'(r_wr_cnt) * 32'(LANES) + 32'(k);
    assign w_ord       = w_erd << r_vsew;
    assign w_wr_off[k] = w_ewr << r_vsew;
    assign w_ard       = w_erd < 32'(r_vl);
`ifdef VRF_MASK_EN
    // Mask bits live in v0 (bytes 0..VB-1); element indices past VLEN see a clear bit.
    assign w_mok = !r_mask_en ||
                   ((w_ewr < 32'(VLEN)) && r_mem[ABITS'(w_ewr >> 3)][w_ewr[2:0]]);
`else
    assign w_mok = 1'b1;
`endif
    assign w_wr_en[k] = w_wr_fire && (w_ewr < 32'(r_vl)) && w_mok;

    always_comb begin
      w_l1 = '0;
      w_l2 = '0;
      w_l3 = '0;
      for (int b = 0; b < 4; b++)
        if (w_ard && (32'(b) < (32'd1 << r_vsew))) begin
          w_l1[8*b +: 8] = r_mem[f_addr(r_vs1, w_ord, 32'(b))];
          w_l2[8*b +: 8] = r_mem[f_addr(r_vs2, w_ord, 32'(b))];
          w_l3[8*b +: 8] = r_mem[f_addr(r_vd,  w_ord, 32'(b))];
        end
    end

    assign rd_vs1_data[32*k +: 32] = w_l1;
    assign rd_vs2_data[32*k +: 32] = w_l2;
    assign rd_vs3_data[32*k +: 32] = w_l3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_vs1    <= '0;
      r_vs2    <= '0;
      r_vd     <= '0;
      r_vsew   <= '0;
      r_vl     <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_err    <= 1'b0;
`ifdef VRF_MASK_EN
      r_mask_en <= 1'b0;
`endif
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_vs1    <= req_vs1;
          r_vs2    <= req_vs2;
          r_vd     <= req_vd;
          r_vsew   <= req_vsew;
          r_vl     <= req_vl;
          r_rd_cnt <= '0;
          r_wr_cnt <= '0;
`ifdef VRF_MASK_EN
          r_mask_en <= req_mask_en;
`endif
          if (req_vsew == 2'd3)   r_err   <= 1'b1;
          else if (req_vl != '0)  r_state <= S_RUN;
        end
        S_RUN: if (rd_ready) begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
          if (rd_last) r_state <= S_DRAIN;
        end
        default: ;
      endcase
      // The final write beat can only land in DRAIN since wr_cnt trails rd_cnt.
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (r_state == S_DRAIN && 32'(r_wr_cnt) + 32'd1 == w_beats) r_state <= S_IDLE;
      end
    end
  end

  // Writes to bytes of v0 (address < VB) are silently dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) r_mem[i] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++)
        for (int b = 0; b < 4; b++)
          if (w_wr_en[k] && (32'(b) < (32'd1 << r_vsew)) &&
              (f_addr(r_vd, w_wr_off[k], 32'(b)) >= ABITS'(VB)))
            r_mem[f_addr(r_vd, w_wr_off[k], 32'(b))] <= wr_data[32*k+8*b +: 8];
    end
  end
endmodule

// File: tb/tb_vector_regfile_seq.sv
// Directed bench for vector_regfile_seq (VLEN=32, LANES=4, default build without mask).
module tb_vector_regfile_seq;
  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_err;
  logic [4:0]   req_vs1, req_vs2, req_vd;
  logic [1:0]   req_vsew;
  logic [7:0]   req_vl;
  logic         rd_valid, rd_ready, rd_last;
  logic [127:0] rd_vs1_data, rd_vs2_data, rd_vs3_data;
  logic         wr_valid, wr_ready;
  logic [127:0] wr_data;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  logic [127:0] d1, d2, d3;
  logic         lst;

  always #5 clk = ~clk;

  vector_regfile_seq #(.VLEN(32), .LANES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd),
    .req_vsew(req_vsew), .req_vl(req_vl), .req_err(req_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .rd_vs1_data(rd_vs1_data), .rd_vs2_data(rd_vs2_data), .rd_vs3_data(rd_vs3_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          input logic [1:0] sew, input logic [7:0] vl);
    @(negedge clk);
    req_vs1 = s1; req_vs2 = s2; req_vd = d; req_vsew = sew; req_vl = vl;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at a negedge; samples the beat, then handshakes it on the next posedge.
  task automatic rd_beat(output logic [127:0] o1, output logic [127:0] o2,
                         output logic [127:0] o3, output logic ol);
    int n = 0;
    while (!rd_valid && n < 20) begin @(negedge clk); n++; end
    if (!rd_valid) chk("rd_timeout", 128'(rd_valid), 128'd1);
    o1 = rd_vs1_data; o2 = rd_vs2_data; o3 = rd_vs3_data; ol = rd_last;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic wr_beat(input logic [127:0] data);
    int n = 0;
    wr_valid = 1'b1; wr_data = data;
    while (!wr_ready && n < 20) begin @(negedge clk); n++; end
    if (!wr_ready) chk("wr_timeout", 128'(wr_ready), 128'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_vs1 = '0; req_vs2 = '0; req_vd = '0; req_vsew = '0; req_vl = '0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_outs", {rd_valid, wr_ready, busy, req_err}, 128'd0);
    chk("rst_rdata", rd_vs1_data | rd_vs2_data | rd_vs3_data, 128'd0);
    reset = 1'b0;

    // Write v4..v7 with one 32-bit beat.
    send_req(5'd0, 5'd0, 5'd4, 2'd2, 8'd4);
    chk("g_busy_last", {busy, rd_valid, rd_last}, 128'b111);
    rd_beat(d1, d2, d3, lst);
    wr_beat({32'h44, 32'h33, 32'h22, 32'h11});
    chk("g_idle", 128'(busy), 128'd0);

    // Read back; vs2=5 shifts by one register, so its last lane is v8 (still 0).
    send_req(5'd4, 5'd5, 5'd20, 2'd2, 8'd4);
    rd_beat(d1, d2, d3, lst);
    chk("g_vs1", d1, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("g_vs2", d2, {32'h0, 32'h44, 32'h33, 32'h22});
    wr_beat('0);

    // Seed v9 so the tail bytes have something to preserve.
    send_req(5'd0, 5'd0, 5'd9, 2'd2, 8'd1);
    rd_beat(d1, d2, d3, lst);
    wr_beat({96'h0, 32'hCAFEBABE});

    // Byte elements, vl=6 across two beats.
    send_req(5'd7, 5'd0, 5'd8, 2'd0, 8'd6);
    rd_beat(d1, d2, d3, lst);
    chk("t_b1_vs1", d1, {32'h0, 32'h0, 32'h0, 32'h44});
    chk("t_b1_last", 128'(lst), 128'd0);
    wr_beat({32'hA3, 32'hA2, 32'hA1, 32'hA0});
    rd_beat(d1, d2, d3, lst);
    chk("t_b2_vs1", d1, {32'h0, 32'h0, 32'hA1, 32'hA0});
    chk("t_b2_vs3", d3, {32'h0, 32'h0, 32'hBA, 32'hBE});
    chk("t_b2_last", 128'(lst), 128'd1);
    wr_beat({32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("t_idle", 128'(busy), 128'd0);

    send_req(5'd8, 5'd0, 5'd20, 2'd2, 8'd2);
    rd_beat(d1, d2, d3, lst);
    chk("t_v8_v9", d1, {32'h0, 32'h0, 32'hCAFEA1A0, 32'hA3A2A1A0});
    wr_beat('0);

    // v0 is write-protected.
    send_req(5'd0, 5'd0, 5'd0, 2'd2, 8'd1);
    rd_beat(d1, d2, d3, lst);
    wr_beat({96'h0, 32'hDEAD});
    send_req(5'd0, 5'd0, 5'd20, 2'd2, 8'd1);
    rd_beat(d1, d2, d3, lst);
    chk("v0_kept", d1, 128'd0);
    wr_beat('0);

    // Backpressure: read held off, early write must wait.
    send_req(5'd4, 5'd0, 5'd20, 2'd2, 8'd4);
    wr_valid = 1'b1; wr_data = '0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_stable", rd_vs1_data, {32'h44, 32'h33, 32'h22, 32'h11});
      chk("bp_wr_rdy", 128'(wr_ready), 128'd0);
      @(negedge clk);
    end
    rd_beat(d1, d2, d3, lst);
    chk("bp_wr_open", 128'(wr_ready), 128'd1);
    wr_beat('0);

    // Degenerate requests.
    send_req(5'd0, 5'd0, 5'd4, 2'd2, 8'd0);
    chk("vl0", {busy, rd_valid, req_err}, 128'd0);
    send_req(5'd0, 5'd0, 5'd4, 2'd3, 8'd4);
    chk("sew3_err", {req_err, busy, rd_valid}, 128'b100);
    @(negedge clk);
    chk("sew3_pulse", 128'(req_err), 128'd0);

    // Reset mid-operation aborts and clears the array.
    send_req(5'd4, 5'd0, 5'd20, 2'd2, 8'd4);
    chk("mid_busy", 128'(busy), 128'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst", {busy, rd_valid, req_ready}, 128'b001);
    @(negedge clk);
    reset = 1'b0;
    send_req(5'd4, 5'd0, 5'd20, 2'd2, 8'd4);
    rd_beat(d1, d2, d3, lst);
    chk("mid_clear", d1, 128'd0);
    wr_beat('0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
